// File: rtl/mkt_frame_pkg.sv
// Shared definitions for the 64-bit market-data frame link (transmit and receive).
package mkt_frame_pkg;
  localparam int TICKER_LSB  = 0;
  localparam int TICKER_W    = 5;
  localparam int ASK_LSB     = 5;
  localparam int ASK_W       = 28;
  localparam int BID_LSB     = 33;
  localparam int BID_W       = 30;
  localparam int FLAG_BIT    = 63;
  localparam int FRAME_W     = 64;
  localparam int FRAME_BYTES = 8;

  // Declared MSB first so the packed layout matches the wire format.
  typedef struct packed {
    logic              flag;
    logic [BID_W-1:0]  bid;
    logic [ASK_W-1:0]  ask;
    logic [TICKER_W-1:0] ticker;
  } frame_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2
  } tx_state_t;
endpackage

// File: rtl/mkt_frame_pack.sv
// Combinational packer: quote fields -> 64-bit frame word.
module mkt_frame_pack
  import mkt_frame_pkg::*;
(
  input  logic [TICKER_W-1:0] ticker,
  input  logic [ASK_W-1:0]    ask,
  input  logic [BID_W-1:0]    bid,
  input  logic                flag,
  output logic [FRAME_W-1:0]  frame
);
  frame_t f;

  assign f.ticker = ticker;
  assign f.ask    = ask;
  assign f.bid    = bid;
  assign f.flag   = flag;
  assign frame    = f;
endmodule

// File: rtl/market_frame_tx.sv
// Market-data frame transmitter: one-entry quote buffer feeding an LSB-first byte
// serialiser with optional trailing XOR checksum byte.
//
//   state | meaning
//   IDLE  | no frame in flight; loads the pending quote when one is present
//   SEND  | presenting frame bytes 0..7 from the shift register
//   CSUM  | presenting the XOR of bytes 0..7 as the final byte
module market_frame_tx
  import mkt_frame_pkg::*;
#(
  parameter int CSUM_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_ticker,
  input  logic [27:0]      in_ask,
  input  logic [29:0]      in_bid,
  input  logic             in_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] frames_sent
);
  localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

  tx_state_t          state, state_nxt;
  logic               pend_valid;
  logic [FRAME_W-1:0] pend_frame, quote_frame, shift;
  logic [2:0]         byte_idx;
  logic [7:0]         xacc;
  logic               load, adv, done;

  mkt_frame_pack u_pack (
    .ticker (in_ticker),
    .ask    (in_ask),
    .bid    (in_bid),
    .flag   (in_flag),
    .frame  (quote_frame)
  );

  assign in_ready = !pend_valid;
  assign busy     = pend_valid | (state != IDLE);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    adv       = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (pend_valid) begin
        load      = 1'b1;
        state_nxt = SEND;
      end
      SEND: if (out_ready) begin
        adv = 1'b1;
        if (byte_idx == LAST_IDX) begin
          if (CSUM_EN != 0) state_nxt = CSUM;
          else              done      = 1'b1;
        end
      end
      CSUM: if (out_ready) done = 1'b1;
      default: state_nxt = IDLE;
    endcase
    // Back-to-back: a queued quote starts in the same cycle the last byte leaves.
    if (done) begin
      if (pend_valid) begin
        load      = 1'b1;
        state_nxt = SEND;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_comb begin
    out_valid = (state != IDLE);
    out_data  = 8'h00;
    out_last  = 1'b0;
    if (state == SEND) begin
      out_data = shift[7:0];
      out_last = (CSUM_EN == 0) && (byte_idx == LAST_IDX);
    end else if (state == CSUM) begin
      out_data = xacc;
      out_last = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pend_valid  <= 1'b0;
      pend_frame  <= '0;
      shift       <= '0;
      byte_idx    <= '0;
      xacc        <= 8'h00;
      frames_sent <= '0;
    end else begin
      state <= state_nxt;
      if (in_valid && in_ready) begin
        pend_valid <= 1'b1;
        pend_frame <= quote_frame;
      end else if (load) begin
        pend_valid <= 1'b0;
      end
      if (load) begin
        shift    <= pend_frame;
        byte_idx <= '0;
        xacc     <= 8'h00;
      end else if (adv) begin
        xacc     <= xacc ^ shift[7:0];
        shift    <= shift >> 8;
        byte_idx <= byte_idx + 3'd1;
      end
      if (done) frames_sent <= frames_sent + 1'b1;
    end
  end
endmodule

// File: tb/tb_market_frame_tx.sv
// Bench for market_frame_tx: three parameterisations checked every cycle against a
// queue-style frame model, plus directed scenarios with literal expectations.
module tb_market_frame_tx;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, in_flag;
  logic [4:0]  in_ticker;
  logic [27:0] in_ask;
  logic [29:0] in_bid;
  logic        ir [3];
  logic        ov [3];
  logic        ol [3];
  logic        bz [3];
  logic [7:0]  od [3];
  logic [15:0] fs0, fs1;
  logic [1:0]  fs2;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  market_frame_tx #(.CSUM_EN(1), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_ticker(in_ticker),
    .in_ask(in_ask), .in_bid(in_bid), .in_flag(in_flag), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_last(ol[0]), .busy(bz[0]), .frames_sent(fs0));
  market_frame_tx #(.CSUM_EN(0), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_ticker(in_ticker),
    .in_ask(in_ask), .in_bid(in_bid), .in_flag(in_flag), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_last(ol[1]), .busy(bz[1]), .frames_sent(fs1));
  market_frame_tx #(.CSUM_EN(1), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_ticker(in_ticker),
    .in_ask(in_ask), .in_bid(in_bid), .in_flag(in_flag), .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od[2]), .out_last(ol[2]), .busy(bz[2]), .frames_sent(fs2));

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", nm, d, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_frame(logic [4:0] t, logic [27:0] a, logic [29:0] b, logic f);
    return 64'(t) | (64'(a) << 5) | (64'(b) << 33) | (64'(f) << 63);
  endfunction

  function automatic logic [7:0] mk_csum(logic [63:0] fr);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 8; i++) x ^= fr[8*i +: 8];
    return x;
  endfunction

  function automatic logic [15:0] get_fs(int d);
    case (d)
      0:       return fs0;
      1:       return fs1;
      default: return {14'b0, fs2};
    endcase
  endfunction

  // Model: pending slot plus the list of bytes still to leave for the frame in flight.
  bit          m_pend [3];
  logic [63:0] m_pf   [3];
  logic [7:0]  m_b    [3][9];
  int          m_n    [3];
  int          m_i    [3];
  int          m_cnt  [3];
  bit          chk_en = 0;
  bit          m_acc;
  logic [63:0] m_fr;
  logic [15:0] m_mask;

  logic [7:0] log0[$], log1[$];
  bit         llog0[$], llog1[$];
  int         run0 = 0, last_run0 = 0;

  always begin
    @(negedge clk);
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        m_mask = (d == 2) ? 16'h0003 : 16'hFFFF;
        chk("in_ready", d, ir[d], !m_pend[d]);
        chk("out_valid", d, ov[d], m_n[d] > 0);
        chk("out_data", d, od[d], (m_n[d] > 0) ? m_b[d][m_i[d]] : 8'h00);
        chk("out_last", d, ol[d], m_n[d] == 1);
        chk("busy", d, bz[d], m_pend[d] || (m_n[d] > 0));
        chk("frames_sent", d, get_fs(d), 16'(m_cnt[d]) & m_mask);
      end
    end
    if (ov[0] && out_ready) begin log0.push_back(od[0]); llog0.push_back(ol[0]); end
    if (ov[1] && out_ready) begin log1.push_back(od[1]); llog1.push_back(ol[1]); end
    if (ov[0]) run0++;
    else begin
      if (run0 > 0) last_run0 = run0;
      run0 = 0;
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_pend[d] = 0;
        m_n[d]    = 0;
        m_i[d]    = 0;
        m_cnt[d]  = 0;
        chk_en    = 1;
      end else begin
        m_acc = in_valid && !m_pend[d];
        if (m_n[d] > 0 && out_ready) begin
          m_i[d]++;
          m_n[d]--;
          if (m_n[d] == 0) m_cnt[d]++;
        end
        if (m_n[d] == 0 && m_pend[d]) begin
          m_fr = m_pf[d];
          for (int i = 0; i < 8; i++) m_b[d][i] = m_fr[8*i +: 8];
          m_b[d][8] = mk_csum(m_fr);
          m_i[d]    = 0;
          m_n[d]    = (d == 1) ? 8 : 9;
          m_pend[d] = 0;
        end
        if (m_acc) begin
          m_pend[d] = 1;
          m_pf[d]   = mk_frame(in_ticker, in_ask, in_bid, in_flag);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    log0.delete(); log1.delete(); llog0.delete(); llog1.delete();
  endtask

  task automatic present(input logic [4:0] t, input logic [27:0] a, input logic [29:0] b, input logic f);
    bit got = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_ticker = t; in_ask = a; in_bid = b; in_flag = f;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk); #1;
      if (ir[0]) got = 1;
    end
    chk("accept_timeout", 0, got, 1);
  endtask

  task automatic release_in();
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk); #1;
      if (!bz[0] && !bz[1] && !bz[2]) ok = 1;
    end
    chk("idle_timeout", 0, ok, 1);
  endtask

  logic [7:0] exp_b [9] = '{8'h03, 8'h02, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h80, 8'hC1};
  bit         pat   [11] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
  logic [1:0] wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_ticker = '0; in_ask = '0; in_bid = '0; in_flag = 1'b0;
    chk("model_frame", 0, mk_frame(5'h03, 28'h10, 30'h20, 1'b1), 64'h8000_0040_0000_0203);
    chk("model_csum", 0, mk_csum(64'h8000_0040_0000_0203), 8'hC1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single frame, with and without checksum.
    do_reset();
    present(5'h03, 28'h10, 30'h20, 1'b1);
    release_in();
    wait_idle();
    chk("s1_len", 0, log0.size(), 9);
    for (int i = 0; i < 9 && i < log0.size(); i++) chk("s1_byte", 0, log0[i], exp_b[i]);
    if (llog0.size() == 9) begin
      chk("s1_last_b7", 0, llog0[7], 0);
      chk("s1_last_cs", 0, llog0[8], 1);
    end
    chk("s1_frames", 0, fs0, 1);
    chk("s4_len", 1, log1.size(), 8);
    for (int i = 0; i < 8 && i < log1.size(); i++) chk("s4_byte", 1, log1[i], exp_b[i]);
    if (llog1.size() == 8) chk("s4_last", 1, llog1[7], 1);

    // Back-to-back frames.
    do_reset();
    present(5'h03, 28'h10, 30'h20, 1'b1);
    present(5'h1F, 28'hABCDEF1, 30'h2345_6789, 1'b0);
    release_in();
    wait_idle();
    chk("b2b_run", 0, last_run0, 18);
    chk("b2b_frames", 0, fs0, 2);

    // Backpressure during byte 3.
    do_reset();
    out_ready = 1'b0;
    present(5'h03, 28'h10, 30'h20, 1'b1);
    release_in();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (ov[0]) break;
    end
    for (int k = 0; k < 11; k++) begin
      @(posedge clk); #1 out_ready = pat[k];
      @(negedge clk); #1;
      if (k == 3 || k == 4) begin
        chk("stall_data", 0, od[0], 8'h00);
        chk("stall_valid", 0, ov[0], 1);
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle();
    chk("bp_len", 0, log0.size(), 9);
    for (int i = 0; i < 9 && i < log0.size(); i++) chk("bp_byte", 0, log0[i], exp_b[i]);

    // Reset while byte 4 is on the wire with a quote pending.
    do_reset();
    present(5'h03, 28'h10, 30'h20, 1'b1);
    present(5'h11, 28'h0FF_FFFF, 30'h1, 1'b1);
    release_in();
    for (int k = 0; k < 40; k++) begin
      if (log0.size() == 5 && ov[0]) break;
      @(negedge clk); #1;
    end
    chk("rst_at_byte4", 0, log0.size(), 5);
    chk("rst_pend_full", 0, ir[0], 0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_out_valid", 0, ov[0], 0);
    chk("rst_busy", 0, bz[0], 0);
    chk("rst_in_ready", 0, ir[0], 1);
    chk("rst_frames", 0, fs0, 0);
    log0.delete();
    present(5'h0A, 28'h0, 30'h0, 1'b0);
    release_in();
    wait_idle();
    chk("rst_next_len", 0, log0.size(), 9);
    if (log0.size() > 0) chk("rst_next_b0", 0, log0[0], 8'h0A);
    chk("rst_next_frames", 0, fs0, 1);

    // Counter wrap on the 2-bit instance.
    do_reset();
    for (int j = 0; j < 5; j++) begin
      present(5'($urandom), 28'($urandom), 30'($urandom), 1'($urandom));
      release_in();
      wait_idle();
      chk("wrap_cnt", 2, fs2, wrap_exp[j]);
    end

    // Random traffic, backpressure and occasional resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 2) == 0);
      in_ticker = 5'($urandom);
      in_ask    = 28'($urandom);
      in_bid    = 30'($urandom);
      in_flag   = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b0; out_ready = 1'b1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
